// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial stage.
//   clog2      - ceiling log2, used to size the lane tag
//   p2s_ratio  - number of output samples per input word
//   p2s_state_e - buffer occupancy state, derived from the valid bits
package p2s_pkg;

  typedef enum logic [1:0] {
    P2S_EMPTY = 2'd0,
    P2S_SHIFT = 2'd1,
    P2S_FULL  = 2'd2
  } p2s_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    for (int k = 0; k < 32; k++) begin
      if (rem != 0) begin
        res = res + 1;
        rem = rem >> 1;
      end
    end
    return res;
  endfunction

  function automatic int unsigned p2s_ratio(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/p2s_lane_sel.sv
// p2s_lane_sel: combinational selector picking one OUT_DWIDTH sample out of an
// IN_DWIDTH word, MSB first (lane 0 is the most significant slice).
// Ports:
//   word   in  [IN_DWIDTH-1:0]  word being serialised (bit IN_DWIDTH-1 is the MSB)
//   lane   in  [LANE_W-1:0]     lane index, 0..RATIO-1
//   sample out [OUT_DWIDTH-1:0] selected slice; zero for an out-of-range lane
module p2s_lane_sel
  import p2s_pkg::*;
#(
  parameter int unsigned IN_DWIDTH  = 32,
  parameter int unsigned OUT_DWIDTH = 16,
  localparam int unsigned RATIO     = p2s_ratio(IN_DWIDTH, OUT_DWIDTH),
  localparam int unsigned LANE_W    = clog2(RATIO)
) (
  input  logic [IN_DWIDTH-1:0]  word,
  input  logic [LANE_W-1:0]     lane,
  output logic [OUT_DWIDTH-1:0] sample
);

  // Explicit mux over valid lanes so non-power-of-2 RATIO never reads past the word.
  always_comb begin
    sample = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        sample = word[IN_DWIDTH-1-i*OUT_DWIDTH -: OUT_DWIDTH];
      end
    end
  end

endmodule

// File: rtl/par2ser_gen.sv
// par2ser_gen: parametrised parallel-to-serial stage. Each IN_DWIDTH word is
// split into RATIO = IN_DWIDTH/OUT_DWIDTH samples, most significant first, each
// tagged with its lane index and a last-of-word flag. A current/prefetch word
// pair keeps the output streaming with no bubble between words.
// Optional feature macro: P2S_WORD_CNT_EN (adds word_cnt and last_word_done).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_req/in_ack   input word handshake; in_data bit 0 is the MSB
//   out_req/out_ack output sample handshake
//   out_data        current sample (bit 0 is the MSB)
//   out_lane        lane index of out_data
//   out_last        high on the final lane of a word
//   word_cnt        (P2S_WORD_CNT_EN) count of accepted words, wrapping
//   last_word_done  (P2S_WORD_CNT_EN) high during each last-lane output transfer
module par2ser_gen
  import p2s_pkg::*;
#(
  parameter int unsigned IN_DWIDTH  = 32,
  parameter int unsigned OUT_DWIDTH = 16,
  localparam int unsigned RATIO     = p2s_ratio(IN_DWIDTH, OUT_DWIDTH),
  localparam int unsigned LANE_W    = clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [0:IN_DWIDTH-1]  in_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [0:OUT_DWIDTH-1] out_data,
  output logic [0:LANE_W-1]     out_lane,
  output logic                  out_last
`ifdef P2S_WORD_CNT_EN
  ,
  output logic [0:31]           word_cnt,
  output logic                  last_word_done
`endif
);

  if ((IN_DWIDTH % OUT_DWIDTH) != 0 || RATIO < 2) begin : gen_bad_width
    $error("par2ser_gen: IN_DWIDTH must be an integer multiple >= 2x OUT_DWIDTH");
  end

  logic [IN_DWIDTH-1:0]  cur_word;
  logic                  cur_valid;
  logic [IN_DWIDTH-1:0]  nxt_word;
  logic                  nxt_valid;
  logic [LANE_W-1:0]     lane_cnt;
  logic [OUT_DWIDTH-1:0] sample;
  p2s_state_e            state;

  logic in_xfer;
  logic out_xfer;
  logic last_lane;
  logic last_xfer;

  always_comb begin
    state = P2S_EMPTY;
    if (cur_valid) begin
      state = nxt_valid ? P2S_FULL : P2S_SHIFT;
    end
  end

  // in_ack depends only on registers and rst, never on out_ack.
  assign in_ack    = !rst && (state != P2S_FULL);
  assign in_xfer   = in_req && in_ack;
  assign out_xfer  = cur_valid && out_ack;
  assign last_lane = (lane_cnt == LANE_W'(RATIO - 1));
  assign last_xfer = out_xfer && last_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_word  <= '0;
      cur_valid <= 1'b0;
      nxt_word  <= '0;
      nxt_valid <= 1'b0;
      lane_cnt  <= '0;
    end else begin
      case (state)
        P2S_EMPTY: begin
          if (in_xfer) begin
            cur_word  <= in_data;
            cur_valid <= 1'b1;
            lane_cnt  <= '0;
          end
        end
        P2S_SHIFT: begin
          if (last_xfer) begin
            lane_cnt <= '0;
            // A word arriving on the final lane goes straight to cur_word: no bubble.
            if (in_xfer) begin
              cur_word <= in_data;
            end else begin
              cur_valid <= 1'b0;
            end
          end else begin
            if (out_xfer) begin
              lane_cnt <= lane_cnt + LANE_W'(1);
            end
            if (in_xfer) begin
              nxt_word  <= in_data;
              nxt_valid <= 1'b1;
            end
          end
        end
        P2S_FULL: begin
          if (last_xfer) begin
            cur_word  <= nxt_word;
            nxt_valid <= 1'b0;
            lane_cnt  <= '0;
          end else if (out_xfer) begin
            lane_cnt <= lane_cnt + LANE_W'(1);
          end
        end
        default: begin
          cur_valid <= 1'b0;
          nxt_valid <= 1'b0;
          lane_cnt  <= '0;
        end
      endcase
    end
  end

  p2s_lane_sel #(
    .IN_DWIDTH  (IN_DWIDTH),
    .OUT_DWIDTH (OUT_DWIDTH)
  ) u_lane_sel (
    .word   (cur_word),
    .lane   (lane_cnt),
    .sample (sample)
  );

  assign out_req  = cur_valid;
  assign out_data = sample;
  assign out_lane = lane_cnt;
  assign out_last = last_lane;

`ifdef P2S_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (in_xfer) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt       = word_cnt_q;
  assign last_word_done = last_xfer;
`endif

endmodule
